pipeline_hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage MIPS core.
- Decides each cycle whether the PC and IF/ID registers advance, hold, or flush, and whether a bubble goes into ID/EX.
- Covers load-use and branch-in-decode hazards that the decode/EX forwarding paths cannot resolve.
- Implements the debug halt/drain/single-step handshake with the debug unit.
- Sits beside the decode stage; drives the PC, IF/ID and ID/EX write/flush controls.

---
 rtl/pipeline_pkg.sv | 30 +++
 rtl/hazard_need_detect.sv | 45 ++++
 rtl/pipeline_hazard_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the MIPS pipeline sequencing controller:
// FSM state encoding, default register-index width and hazard stall-need codes.
// Imported by pipeline_hazard_ctrl and hazard_need_detect.
package pipeline_pkg;

  // Default width of a register index (32 architectural registers)
  localparam int NB_REG_DEF = 5;

  // Sequencing controller states
  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_STALL  = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_HALTED = 3'd3,
    ST_STEP   = 3'd4
  } state_t;

  // Number of bubble cycles the instruction in ID must wait
  typedef logic [1:0] need_t;

  localparam need_t NEED_NONE = 2'd0;
  localparam need_t NEED_ONE  = 2'd1;
  localparam need_t NEED_TWO  = 2'd2;

  // True when the decode instruction cannot leave ID this cycle
  function automatic logic is_stall(input need_t need);
    return need != NEED_NONE;
  endfunction

endpackage

// File: rtl/hazard_need_detect.sv
// Combinational hazard classifier for the instruction sitting in ID.
// Zero latency: need is a pure function of the current ID/EX/MEM indices and controls.
// No flow control of its own; the sequencing FSM acts on the need code.
module hazard_need_detect
  import pipeline_pkg::*;
#(
  parameter int NB_REG = NB_REG_DEF
) (
  input  logic [NB_REG-1:0] rs_dec,
  input  logic [NB_REG-1:0] rt_dec,
  input  logic              uses_rt_dec,
  input  logic              branch_dec,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic [NB_REG-1:0] ex_write_reg,
  input  logic              mem_mem_read,
  input  logic [NB_REG-1:0] mem_write_reg,
  output need_t             need
);

  logic ex_match;
  logic mem_match;

  // r0 is hardwired to zero, so a write to it never creates a dependency.
  assign ex_match  = (ex_write_reg != '0) &&
                     ((rs_dec == ex_write_reg) || (uses_rt_dec && (rt_dec == ex_write_reg)));
  assign mem_match = (mem_write_reg != '0) &&
                     ((rs_dec == mem_write_reg) || (uses_rt_dec && (rt_dec == mem_write_reg)));

  // Classify the dependency. Branches compare in ID, so they need operands one
  // stage earlier than ALU ops: an ALU result in EX or a load in MEM costs one
  // bubble, and a load in EX costs two. Non-branch consumers only wait on a
  // load in EX; everything else is covered by the EX forwarding paths.
  always_comb begin
    need = NEED_NONE;
    if (ex_mem_read && ex_match && branch_dec) begin
      need = NEED_TWO;
    end else if ((ex_mem_read && ex_match) ||
                 (ex_reg_write && ex_match && branch_dec) ||
                 (mem_mem_read && mem_match && branch_dec)) begin
      need = NEED_ONE;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: PC / IF/ID write, IF/ID flush and ID/EX bubble
// control for load-use and branch-in-decode hazards, plus debug halt/drain/step.
// Outputs are combinational from the registered state and current inputs.
// Optional stall-cycle counter enabled by defining HAZARD_STALL_COUNT_EN.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int NB_REG     = NB_REG_DEF,
  parameter int PIPE_DRAIN = 4,
  parameter int NB_CNT     = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NB_REG-1:0] rs_dec_i,
  input  logic [NB_REG-1:0] rt_dec_i,
  input  logic              uses_rt_dec_i,
  input  logic              branch_dec_i,
  input  logic              branch_taken_i,
  input  logic              ex_mem_read_i,
  input  logic              ex_reg_write_i,
  input  logic [NB_REG-1:0] ex_write_reg_i,
  input  logic              mem_mem_read_i,
  input  logic [NB_REG-1:0] mem_write_reg_i,
  input  logic              halt_req_i,
  input  logic              step_req_i,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              idex_bubble_o,
  output logic              halted_o,
  output logic [NB_CNT-1:0] stall_cycles_o
);

  // Wide enough to hold PIPE_DRAIN, the value loaded after a single step.
  localparam int CNT_W = $clog2(PIPE_DRAIN + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  need_t            need;

  hazard_need_detect #(
    .NB_REG(NB_REG)
  ) u_need (
    .rs_dec       (rs_dec_i),
    .rt_dec       (rt_dec_i),
    .uses_rt_dec  (uses_rt_dec_i),
    .branch_dec   (branch_dec_i),
    .ex_mem_read  (ex_mem_read_i),
    .ex_reg_write (ex_reg_write_i),
    .ex_write_reg (ex_write_reg_i),
    .mem_mem_read (mem_mem_read_i),
    .mem_write_reg(mem_write_reg_i),
    .need         (need)
  );

  // Output decode. The default is the hold/bubble pattern, which is also what
  // the pipeline sees while reset is asserted; only RUN without a hazard or a
  // pending halt, and the single STEP cycle, let fetch advance.
  always_comb begin
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b1;
    halted_o      = 1'b0;
    if (!reset) begin
      unique case (state)
        ST_RUN: begin
          if (!is_stall(need) && !halt_req_i) begin
            pc_write_o    = 1'b1;
            ifid_write_o  = 1'b1;
            idex_bubble_o = 1'b0;
            // A taken branch resolved in ID squashes the wrong-path fetch.
            ifid_flush_o  = branch_taken_i;
          end
        end
        ST_STALL: begin
          // Second bubble of a load feeding a branch; inputs are ignored.
        end
        ST_DRAIN: begin
          // Fetch stopped; older instructions retire behind the bubbles.
        end
        ST_HALTED: begin
          halted_o = 1'b1;
        end
        ST_STEP: begin
          // Let exactly one instruction move forward through IF/ID and ID/EX.
          pc_write_o    = 1'b1;
          ifid_write_o  = 1'b1;
          idex_bubble_o = 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // Sequencing FSM with the shared stall/drain down-counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      unique case (state)
        ST_RUN: begin
          // A one-cycle hazard simply re-evaluates next cycle in RUN; a halt is
          // only accepted once the ID instruction has no outstanding hazard.
          if (need == NEED_TWO) begin
            state <= ST_STALL;
            cnt   <= CNT_W'(1);
          end else if (!is_stall(need) && halt_req_i) begin
            state <= ST_DRAIN;
            cnt   <= CNT_W'(PIPE_DRAIN - 1);
          end
        end
        ST_STALL: begin
          // Leave once the count has been used up; a halt request waits for RUN.
          if (cnt <= CNT_W'(1)) begin
            state <= ST_RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (cnt == '0) begin
            state <= ST_HALTED;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_HALTED: begin
          // A step wins over a simultaneous halt release.
          if (step_req_i) begin
            state <= ST_STEP;
          end else if (!halt_req_i) begin
            state <= ST_RUN;
          end
        end
        ST_STEP: begin
          // The stepped instruction is one stage further in than a normal
          // drain start, hence the full PIPE_DRAIN count.
          state <= ST_DRAIN;
          cnt   <= CNT_W'(PIPE_DRAIN);
        end
        default: begin
          state <= ST_RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_STALL_COUNT_EN
  logic [NB_CNT-1:0] stall_cnt;

  // Count bubble cycles spent in RUN/STALL, saturating at all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (((state == ST_RUN) || (state == ST_STALL)) && idex_bubble_o &&
                 !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + NB_CNT'(1);
    end
  end

  assign stall_cycles_o = stall_cnt;
`else
  assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: table of single-cycle RUN
// vectors plus hand sequences for two-cycle stall, halt/drain, step and reset.
// Expected results go through a scoreboard queue and are compared at negedge.
module tb_pipeline_hazard_ctrl;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic       br;
    logic       tk;
    logic       exl;
    logic       exw;
    logic [4:0] exd;
    logic       meml;
    logic [4:0] memd;
    logic       halt;
    logic       step;
  } in_t;

  typedef struct {
    logic pc;
    logic ifid;
    logic flush;
    logic bub;
    logic halted;
    logic inc;
    logic bub_dc;
  } exp_t;

  typedef struct {
    in_t  in;
    exp_t ex;
  } vec_t;

  logic        clock;
  logic        reset;
  logic [4:0]  rs_dec_i, rt_dec_i, ex_write_reg_i, mem_write_reg_i;
  logic        uses_rt_dec_i, branch_dec_i, branch_taken_i;
  logic        ex_mem_read_i, ex_reg_write_i, mem_mem_read_i;
  logic        halt_req_i, step_req_i;
  logic        pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, halted_o;
  logic [31:0] stall_cycles_o;

  int   errors = 0;
  int   checks = 0;
  int   exp_stall = 0;
  exp_t sb[$];

  pipeline_hazard_ctrl #(
    .NB_REG(5),
    .PIPE_DRAIN(4),
    .NB_CNT(32)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .rs_dec_i       (rs_dec_i),
    .rt_dec_i       (rt_dec_i),
    .uses_rt_dec_i  (uses_rt_dec_i),
    .branch_dec_i   (branch_dec_i),
    .branch_taken_i (branch_taken_i),
    .ex_mem_read_i  (ex_mem_read_i),
    .ex_reg_write_i (ex_reg_write_i),
    .ex_write_reg_i (ex_write_reg_i),
    .mem_mem_read_i (mem_mem_read_i),
    .mem_write_reg_i(mem_write_reg_i),
    .halt_req_i     (halt_req_i),
    .step_req_i     (step_req_i),
    .pc_write_o     (pc_write_o),
    .ifid_write_o   (ifid_write_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_bubble_o  (idex_bubble_o),
    .halted_o       (halted_o),
    .stall_cycles_o (stall_cycles_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic in_t I(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                            input logic br, input logic tk, input logic exl, input logic exw,
                            input logic [4:0] exd, input logic meml, input logic [4:0] memd);
    in_t v;
    v.rs = rs; v.rt = rt; v.urt = urt; v.br = br; v.tk = tk;
    v.exl = exl; v.exw = exw; v.exd = exd; v.meml = meml; v.memd = memd;
    v.halt = 1'b0; v.step = 1'b0;
    return v;
  endfunction

  function automatic in_t H(input in_t v, input logic halt, input logic step);
    in_t r;
    r = v;
    r.halt = halt;
    r.step = step;
    return r;
  endfunction

  function automatic exp_t E(input logic pc, input logic ifid, input logic flush,
                             input logic bub, input logic halted, input logic inc);
    exp_t e;
    e.pc = pc; e.ifid = ifid; e.flush = flush; e.bub = bub;
    e.halted = halted; e.inc = inc; e.bub_dc = 1'b0;
    return e;
  endfunction

  function automatic int exp_sc();
`ifdef HAZARD_STALL_COUNT_EN
    return exp_stall;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic apply(input in_t v);
    rs_dec_i        = v.rs;
    rt_dec_i        = v.rt;
    uses_rt_dec_i   = v.urt;
    branch_dec_i    = v.br;
    branch_taken_i  = v.tk;
    ex_mem_read_i   = v.exl;
    ex_reg_write_i  = v.exw;
    ex_write_reg_i  = v.exd;
    mem_mem_read_i  = v.meml;
    mem_write_reg_i = v.memd;
    halt_req_i      = v.halt;
    step_req_i      = v.step;
  endtask

  task automatic check_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s.scoreboard: got 0 entries expected 1", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".pc_write"}, {31'd0, pc_write_o}, {31'd0, e.pc});
    chk({tag, ".ifid_write"}, {31'd0, ifid_write_o}, {31'd0, e.ifid});
    chk({tag, ".ifid_flush"}, {31'd0, ifid_flush_o}, {31'd0, e.flush});
    if (!e.bub_dc) chk({tag, ".idex_bubble"}, {31'd0, idex_bubble_o}, {31'd0, e.bub});
    chk({tag, ".halted"}, {31'd0, halted_o}, {31'd0, e.halted});
    chk({tag, ".stall_cycles"}, stall_cycles_o, exp_sc());
    if (e.inc) exp_stall++;
  endtask

  // One clock cycle: drive after posedge, push expectation, compare at negedge.
  task automatic cycle(input string tag, input in_t v, input exp_t e);
    apply(v);
    sb.push_back(e);
    @(negedge clock);
    check_pop(tag);
    @(posedge clock);
    #1;
  endtask

  initial begin
    vec_t tbl[15];
    in_t  clr, n2, n1h;
    exp_t go, st1, fl, drn, hlt, stp, hold;

    clr  = I(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    go   = E(1, 1, 0, 0, 0, 0);
    st1  = E(0, 0, 0, 1, 0, 1);
    fl   = E(1, 1, 1, 0, 0, 0);
    hold = E(0, 0, 0, 1, 0, 1);
    drn  = E(0, 0, 0, 1, 0, 0);
    hlt  = E(0, 0, 0, 1, 1, 0);
    stp  = E(1, 1, 0, 0, 0, 0);
    stp.bub_dc = 1'b1;

    tbl[0]  = '{I(1, 2, 1, 0, 0, 0, 1, 3, 0, 0), go};   // no dependency
    tbl[1]  = '{I(5, 2, 1, 0, 0, 1, 1, 5, 0, 0), st1};  // load-use on rs
    tbl[2]  = '{I(1, 5, 1, 0, 0, 1, 1, 5, 0, 0), st1};  // load-use on rt
    tbl[3]  = '{I(1, 5, 0, 0, 0, 1, 1, 5, 0, 0), go};   // rt not a source
    tbl[4]  = '{I(0, 0, 1, 0, 0, 1, 1, 0, 0, 0), go};   // load to r0
    tbl[5]  = '{I(7, 0, 1, 1, 0, 0, 1, 7, 0, 0), st1};  // ALU in EX feeds branch
    tbl[6]  = '{I(7, 0, 1, 0, 0, 0, 1, 7, 0, 0), go};   // ALU in EX feeds ALU
    tbl[7]  = '{I(1, 9, 1, 1, 0, 0, 0, 0, 1, 9), st1};  // load in MEM feeds branch
    tbl[8]  = '{I(9, 2, 1, 0, 0, 0, 0, 0, 1, 9), go};   // load in MEM feeds ALU
    tbl[9]  = '{I(3, 4, 1, 1, 1, 0, 1, 8, 0, 0), fl};   // taken branch, no hazard
    tbl[10] = '{I(7, 0, 1, 1, 1, 0, 1, 7, 0, 0), st1};  // taken but stalled: no flush
    tbl[11] = '{I(6, 0, 1, 1, 0, 0, 0, 6, 0, 0), go};   // EX not writing
    tbl[12] = '{I(0, 0, 1, 1, 1, 0, 1, 0, 0, 0), fl};   // beq r0,r0 after ALU to r0
    tbl[13] = '{I(4, 4, 1, 1, 0, 0, 1, 8, 0, 4), go};   // MEM is not a load
    tbl[14] = '{I(0, 0, 1, 1, 0, 0, 0, 0, 1, 0), go};   // MEM load to r0

    // Reset state: hazard-free inputs would advance, but reset forces hold/bubble.
    reset = 1'b1;
    apply(clr);
    #2;
    chk("reset.pc_write", {31'd0, pc_write_o}, 32'd0);
    chk("reset.ifid_write", {31'd0, ifid_write_o}, 32'd0);
    chk("reset.ifid_flush", {31'd0, ifid_flush_o}, 32'd0);
    chk("reset.idex_bubble", {31'd0, idex_bubble_o}, 32'd1);
    chk("reset.halted", {31'd0, halted_o}, 32'd0);
    chk("reset.stall_cycles", stall_cycles_o, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    for (int i = 0; i < 15; i++) begin
      cycle($sformatf("vec%0d", i), tbl[i].in, tbl[i].ex);
    end

    // Load in EX feeding a branch: two bubbles even though the hazard clears
    // and a taken branch shows up during the second one.
    n2 = I(5, 0, 1, 1, 0, 1, 1, 5, 0, 0);
    cycle("ld_br.c0", n2, st1);
    cycle("ld_br.c1", I(5, 0, 1, 1, 1, 0, 0, 0, 0, 0), st1);
    cycle("ld_br.c2", I(5, 0, 1, 1, 0, 0, 0, 0, 0, 0), go);

    // Halt waits for a hazard to clear, then drains for PIPE_DRAIN cycles with
    // hazard and branch inputs ignored, then reports halted.
    n1h = H(I(5, 2, 1, 0, 0, 1, 1, 5, 0, 0), 1, 0);
    cycle("halt.haz", n1h, st1);
    cycle("halt.req", H(clr, 1, 0), hold);
    for (int i = 0; i < 4; i++) begin
      cycle($sformatf("halt.drain%0d", i), H(I(5, 0, 1, 1, 1, 1, 1, 5, 0, 0), 1, 0), drn);
    end
    cycle("halt.h0", H(n2, 1, 0), hlt);
    cycle("halt.h1", H(clr, 1, 0), hlt);

    // Single step while the halt stays requested.
    cycle("step.req", H(clr, 1, 1), hlt);
    cycle("step.go", H(clr, 1, 0), stp);
    for (int i = 0; i < 5; i++) begin
      cycle($sformatf("step.drain%0d", i), H(clr, 1, 0), drn);
    end
    cycle("step.h", H(clr, 1, 0), hlt);

    // Step together with halt release: step wins, then resume.
    cycle("pri.req", H(clr, 0, 1), hlt);
    cycle("pri.step", clr, stp);
    for (int i = 0; i < 5; i++) begin
      cycle($sformatf("pri.drain%0d", i), clr, drn);
    end
    cycle("pri.h", clr, hlt);
    cycle("pri.run", clr, go);

    // Reset in the middle of a drain (counter at 2).
    cycle("rst.req", H(clr, 1, 0), hold);
    cycle("rst.drain3", H(clr, 1, 0), drn);
    reset = 1'b1;
    apply(clr);
    #1;
    chk("rst.pc_write", {31'd0, pc_write_o}, 32'd0);
    chk("rst.idex_bubble", {31'd0, idex_bubble_o}, 32'd1);
    chk("rst.halted", {31'd0, halted_o}, 32'd0);
    chk("rst.stall_cycles", stall_cycles_o, 32'd0);
    exp_stall = 0;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    cycle("rst.run", clr, go);
    cycle("rst.load_use", I(5, 3, 1, 0, 0, 1, 1, 5, 0, 0), st1);
    cycle("rst.after", clr, go);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
